sd_sector_cache: RTL and testbench



---
 rtl/fdd_pkg.sv | 17 +
 rtl/sector_dpram.sv | 35 +++
 rtl/sd_sector_cache.sv | 134 +++++++++++++
 tb/tb_sd_sector_cache.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fdd_pkg.sv
// Shared types and constants for the per-drive SD sector cache.
package fdd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      RD_REQ,
      RD_XFER,
      WR_REQ,
      WR_XFER,
      FIN
   } sect_state_t;

   localparam int SECTOR_BYTES = 512;
   localparam int SECTOR_SHIFT = 9;

endpackage

// File: rtl/sector_dpram.sv
// True dual-port byte RAM with registered read ports; A = SD side, B = CPU side.
module sector_dpram #(
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [AW-1:0] a_addr,
   input  logic          a_we,
   input  logic [7:0]    a_wdata,
   output logic [7:0]    a_rdata,
   input  logic [AW-1:0] b_addr,
   input  logic          b_we,
   input  logic [7:0]    b_wdata,
   output logic [7:0]    b_rdata
);

   logic [7:0] mem [0:(1<<AW)-1];

   // Both write ports share one process; the cache never enables them together.
   always_ff @(posedge clk) begin
      if (a_we) mem[a_addr] <= a_wdata;
      if (b_we) mem[b_addr] <= b_wdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a_rdata <= 8'h00;
         b_rdata <= 8'h00;
      end else begin
         a_rdata <= mem[a_addr];
         b_rdata <= mem[b_addr];
      end
   end

endmodule

// File: rtl/sd_sector_cache.sv
// Single-sector cache between the hps_io block SD lane and one floppy drive.
module sd_sector_cache
   import fdd_pkg::*;
#(
   parameter int SECT_AW = 9
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               img_mounted,
   input  logic [63:0]        img_size,
   input  logic               req,
   input  logic               req_write,
   input  logic [31:0]        req_lba,
   output logic               busy,
   output logic               done,
   output logic               err,
   input  logic [SECT_AW-1:0] cpu_addr,
   output logic [7:0]         cpu_rdata,
   input  logic               cpu_we,
   input  logic [7:0]         cpu_wdata,
   output logic [31:0]        sd_lba,
   output logic [5:0]         sd_blk_cnt,
   output logic               sd_rd,
   output logic               sd_wr,
   input  logic               sd_ack,
   input  logic [13:0]        sd_buff_addr,
   input  logic [7:0]         sd_buff_dout,
   output logic [7:0]         sd_buff_din,
   input  logic               sd_buff_wr
);

   sect_state_t state, state_n;
   logic [31:0] lat_lba, cached_lba;
   logic        lat_wr, valid, abort;
   logic        range_err, hit, sd_phase, xfer_end;
   logic        unused_bits;

   assign unused_bits = ^{img_size[63:41], sd_buff_addr[13:SECT_AW]};

   assign busy       = (state != IDLE);
   assign sd_blk_cnt = 6'd0;
   assign range_err  = (img_size == 64'd0) || (lat_lba >= img_size[SECTOR_SHIFT +: 32]);
   assign hit        = valid && !img_mounted && (cached_lba == lat_lba);
   assign sd_phase   = (state == RD_REQ) || (state == RD_XFER) ||
                       (state == WR_REQ) || (state == WR_XFER);
   assign xfer_end   = ((state == RD_XFER) || (state == WR_XFER)) && !sd_ack;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (req) state_n = CHECK;
         CHECK: begin
            if (range_err)   state_n = FIN;
            else if (lat_wr) state_n = WR_REQ;
            else if (hit)    state_n = FIN;
            else             state_n = RD_REQ;
         end
         RD_REQ:  if (sd_ack)  state_n = RD_XFER;
         RD_XFER: if (!sd_ack) state_n = FIN;
         WR_REQ:  if (sd_ack)  state_n = WR_XFER;
         WR_XFER: if (!sd_ack) state_n = FIN;
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lat_lba    <= 32'd0;
         lat_wr     <= 1'b0;
         cached_lba <= 32'd0;
         valid      <= 1'b0;
         abort      <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         sd_rd      <= 1'b0;
         sd_wr      <= 1'b0;
         sd_lba     <= 32'd0;
      end else begin
         done <= (state == FIN);
         if (state == IDLE && req) begin
            lat_lba <= req_lba;
            lat_wr  <= req_write;
            err     <= 1'b0;
            abort   <= 1'b0;
         end
         if (state == CHECK) begin
            if (range_err) begin
               err <= 1'b1;
            end else if (state_n == RD_REQ) begin
               // The buffer is about to be overwritten, so the old tag is dead.
               valid  <= 1'b0;
               sd_rd  <= 1'b1;
               sd_lba <= lat_lba;
            end else if (state_n == WR_REQ) begin
               sd_wr  <= 1'b1;
               sd_lba <= lat_lba;
            end
         end
         if ((state == RD_REQ || state == WR_REQ) && sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
         end
         if (sd_phase && img_mounted) abort <= 1'b1;
         if (xfer_end) begin
            err <= abort | img_mounted;
            if (!(abort | img_mounted)) begin
               cached_lba <= lat_lba;
               valid      <= 1'b1;
            end
         end
         if (img_mounted) valid <= 1'b0;
      end
   end

   sector_dpram #(.AW(SECT_AW)) u_ram (
      .clk     (clk),
      .rstn    (rstn),
      .a_addr  (sd_buff_addr[SECT_AW-1:0]),
      .a_we    ((state == RD_XFER) && sd_ack && sd_buff_wr),
      .a_wdata (sd_buff_dout),
      .a_rdata (sd_buff_din),
      .b_addr  (cpu_addr),
      .b_we    (cpu_we && !busy),
      .b_wdata (cpu_wdata),
      .b_rdata (cpu_rdata)
   );

endmodule

// File: tb/tb_sd_sector_cache.sv
// Directed bench for sd_sector_cache with a request-level cache model and a byte-array buffer model.
module tb_sd_sector_cache;

   logic        clk = 1'b0, rstn = 1'b0;
   logic        img_mounted = 1'b0;
   logic [63:0] img_size = 64'd1474560;
   logic        req = 1'b0, req_write = 1'b0;
   logic [31:0] req_lba = 32'd0;
   logic        busy, done, err;
   logic [8:0]  cpu_addr = 9'd0;
   logic [7:0]  cpu_rdata;
   logic        cpu_we = 1'b0;
   logic [7:0]  cpu_wdata = 8'd0;
   logic [31:0] sd_lba;
   logic [5:0]  sd_blk_cnt;
   logic        sd_rd, sd_wr;
   logic        sd_ack = 1'b0;
   logic [13:0] sd_buff_addr = 14'd0;
   logic [7:0]  sd_buff_dout = 8'd0;
   logic [7:0]  sd_buff_din;
   logic        sd_buff_wr = 1'b0;

   sd_sector_cache #(.SECT_AW(9)) dut (
      .clk(clk), .rstn(rstn), .img_mounted(img_mounted), .img_size(img_size),
      .req(req), .req_write(req_write), .req_lba(req_lba),
      .busy(busy), .done(done), .err(err),
      .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
      .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt), .sd_rd(sd_rd), .sd_wr(sd_wr),
      .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
      .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
   endtask

   // Buffer model: what each byte must hold, and whether it is known yet.
   logic [7:0] mem_m [512];
   bit         mem_k [512];
   bit         sd_fill = 0, blk_we = 0, chk_sd = 0;
   logic [7:0] exp_cpu, exp_sd;
   bit         exp_cpu_k = 0, exp_sd_k = 0;

   // Cache model: tag and validity as the rules define them.
   bit          m_valid = 0;
   logic [31:0] m_lba = 32'd0;

   always @(posedge clk) begin
      if (!rstn) begin
         exp_cpu_k = 0;
         exp_sd_k  = 0;
      end else begin
         exp_cpu   = mem_m[cpu_addr];
         exp_cpu_k = mem_k[cpu_addr];
         exp_sd    = mem_m[sd_buff_addr[8:0]];
         exp_sd_k  = mem_k[sd_buff_addr[8:0]] && chk_sd;
         if (sd_fill && sd_buff_wr && sd_ack) begin
            mem_m[sd_buff_addr[8:0]] = sd_buff_dout;
            mem_k[sd_buff_addr[8:0]] = 1;
         end
         if (cpu_we && !blk_we) begin
            mem_m[cpu_addr] = cpu_wdata;
            mem_k[cpu_addr] = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rstn) begin
         if (exp_cpu_k) check("cpu_rdata", cpu_rdata, exp_cpu);
         if (exp_sd_k)  check("sd_buff_din", sd_buff_din, exp_sd);
         check("sd_blk_cnt", sd_blk_cnt, 0);
         check("rd_wr_exclusive", sd_rd & sd_wr, 0);
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_sd_rd"}, sd_rd, 0);
      check({tag, "_sd_wr"}, sd_wr, 0);
      check({tag, "_sd_lba"}, sd_lba, 0);
      check({tag, "_sd_buff_din"}, sd_buff_din, 0);
      check({tag, "_cpu_rdata"}, cpu_rdata, 0);
   endtask

   // abort: 0 none, 1 mount pulse mid-transfer, 2 reset mid-transfer.
   task automatic do_req(input bit wr, input logic [31:0] lba, input int nbytes,
                         input int abort, input bit try_we);
      bit range_bad, hit, sd_exp, saw_sd;
      int lat;
      range_bad = (img_size == 0) || ({32'd0, lba} >= img_size / 512);
      hit       = !wr && m_valid && (m_lba == lba);
      sd_exp    = !range_bad && !hit;
      saw_sd    = 0;
      @(negedge clk);
      req = 1; req_write = wr; req_lba = lba;
      @(negedge clk);
      req = 0;
      check("busy_after_req", busy, 1);
      if (sd_exp) begin
         for (int k = 0; k < 20 && !(wr ? sd_wr : sd_rd); k++) @(negedge clk);
         check(wr ? "sd_wr_seen" : "sd_rd_seen", wr ? sd_wr : sd_rd, 1);
         check("sd_lba", sd_lba, lba);
         if (!wr) m_valid = 0;
         sd_ack = 1;
         @(negedge clk);
         check("req_drop_on_ack", wr ? sd_wr : sd_rd, 0);
         for (int i = 0; i < nbytes; i++) begin
            sd_buff_addr = 14'(i);
            if (!wr) begin
               sd_buff_wr = 1; sd_buff_dout = 8'(i); sd_fill = 1;
            end else begin
               chk_sd = 1;
            end
            img_mounted = (abort == 1) && (i == nbytes / 2);
            if (abort == 2 && i == nbytes / 2) begin
               #2 rstn = 0;
               #1 check_reset_values("reset_mid");
               sd_buff_wr = 0; sd_fill = 0; sd_ack = 0;
               @(negedge clk);
               #2 rstn = 1;
               m_valid = 0;
               return;
            end
            @(negedge clk);
            if (wr && i == 16) check("wb_byte_0x010", sd_buff_din, 8'hA5);
         end
         img_mounted = 0; sd_buff_wr = 0; sd_fill = 0; chk_sd = 0;
         sd_ack = 0;
         for (int k = 0; k < 20 && !done; k++) @(negedge clk);
         check("done_seen", done, 1);
         check("busy_at_done", busy, 0);
         check("err_xfer", err, (abort == 1) ? 1 : 0);
         if (abort == 1) m_valid = 0;
         else begin
            m_valid = 1; m_lba = lba;
         end
      end else begin
         lat = 1;
         while (!done && lat < 10) begin
            if (try_we && lat == 1) begin
               cpu_we = 1; cpu_addr = 9'h1FF; cpu_wdata = 8'h00; blk_we = 1;
            end
            @(negedge clk);
            lat++;
            cpu_we = 0; blk_we = 0;
            saw_sd |= (sd_rd | sd_wr);
         end
         check("done_latency", lat, 3);
         check("no_sd_traffic", saw_sd, 0);
         check("busy_at_done", busy, 0);
         check("err_nosd", err, range_bad);
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem_k[i] = 0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      #2 rstn = 1;

      // Read miss: bytes 0x00..0xFF twice.
      do_req(0, 32'd5, 512, 0, 0);
      cpu_addr = 9'h1FF;
      @(negedge clk); @(negedge clk);
      check("rd_byte_0x1ff", cpu_rdata, 8'hFF);

      // Read hit with a CPU write attempted while busy (must be dropped).
      do_req(0, 32'd5, 0, 0, 1);
      cpu_addr = 9'h1FF;
      @(negedge clk); @(negedge clk);
      check("blocked_we_0x1ff", cpu_rdata, 8'hFF);

      // Write-back of a CPU-modified byte.
      cpu_we = 1; cpu_addr = 9'h010; cpu_wdata = 8'hA5;
      @(negedge clk);
      cpu_we = 0;
      do_req(1, 32'd5, 32, 0, 0);
      do_req(0, 32'd5, 0, 0, 0);

      // Range boundaries and empty image.
      do_req(0, 32'd2880, 0, 0, 0);
      do_req(0, 32'd2879, 4, 0, 0);
      img_size = 64'd0;
      do_req(0, 32'd0, 0, 0, 0);
      img_size = 64'd1474560;

      // Mount during RD_XFER, then the same sector must miss.
      do_req(0, 32'd5, 0, 0, 0);
      do_req(0, 32'd7, 64, 1, 0);
      do_req(0, 32'd5, 512, 0, 0);

      // Reset during RD_XFER, then the same sector must miss.
      do_req(0, 32'd9, 64, 2, 0);
      do_req(0, 32'd9, 512, 0, 0);
      do_req(0, 32'd9, 0, 0, 0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
